commit_unit: RTL and testbench

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit.sv | 169 ++++++++++++++++
 tb/tb_commit_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// Commit stage: retires the ROB head into the register file, releases stores and flushes
// on exceptions. Define COMMIT_COUNTER_EN to build the retired-entry counter.
package commit_unit_pkg;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned N_STATIONS_W = 4;

    typedef struct packed {
        logic                    invalidate;
        logic [N_STATIONS_W-1:0] station_id;
        logic [6:0]              opcode;
        logic [REG_ADDR_W-1:0]   dst_reg;
        logic [DATA_W-1:0]       content;
    } station_t;
endpackage

module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [6:0]  OPC_STORE    = 7'b0100011,
    parameter logic [6:0]  OPC_FSTORE   = 7'b0100111
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    i_valid,
    input  station_t                i_commit_data,
    input  logic                    i_exception,
    output logic                    i_ready,
    output logic                    reg_we,
    output logic [REG_ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]       reg_data,
    output logic                    store_valid,
    output logic [N_STATIONS_W-1:0] store_id,
    input  logic                    store_ready,
    output logic                    clear,
    output logic                    exc_valid,
    output logic [N_STATIONS_W-1:0] exc_id,
    output logic [31:0]             retired_count
);

    typedef enum logic [1:0] {StRun, StStoreWait, StFlush} state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;

    logic                    reg_we_q, exc_valid_q;
    logic [REG_ADDR_W-1:0]   reg_addr_q;
    logic [DATA_W-1:0]       reg_data_q;
    logic [N_STATIONS_W-1:0] store_id_q, exc_id_q;

    logic accept, live, is_store;
    logic take_exc, take_store, take_write;

    // Invalidate wins over everything, exception wins over store/write.
    assign accept     = i_valid & i_ready;
    assign live       = accept & ~i_commit_data.invalidate;
    assign is_store   = (i_commit_data.opcode == OPC_STORE) |
                        (i_commit_data.opcode == OPC_FSTORE);
    assign take_exc   = live & i_exception;
    assign take_store = live & ~i_exception & is_store;
    assign take_write = live & ~i_exception & ~is_store & (i_commit_data.dst_reg != '0);

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StRun: begin
                if (take_exc) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end else if (take_store) begin
                    state_d = StStoreWait;
                end
            end
            StStoreWait: begin
                if (store_ready) begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        i_ready     = (state_q == StRun);
        store_valid = (state_q == StStoreWait);
        clear       = (state_q == StFlush);
    end

    // Strobes last one cycle; payload registers hold their last value between strobes.
    always_ff @(posedge clk) begin
        if (nrst) begin
            reg_we_q    <= 1'b0;
            exc_valid_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            store_id_q  <= '0;
            exc_id_q    <= '0;
        end else begin
            reg_we_q    <= take_write;
            exc_valid_q <= take_exc;
            if (take_write) begin
                reg_addr_q <= i_commit_data.dst_reg;
                reg_data_q <= i_commit_data.content;
            end
            if (take_store) begin
                store_id_q <= i_commit_data.station_id;
            end
            if (take_exc) begin
                exc_id_q <= i_commit_data.station_id;
            end
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;
    assign store_id  = store_id_q;
    assign exc_valid = exc_valid_q;
    assign exc_id    = exc_id_q;

`ifdef COMMIT_COUNTER_EN
    logic        retire;
    logic [31:0] retired_q, retired_d;

    assign retire    = live & ~i_exception;
    assign retired_d = retired_q + 32'd1;

    always_ff @(posedge clk) begin
        if (nrst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

    a_flush_range: assert property (@(posedge clk) (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 15));
    a_we_vs_store: assert property (@(posedge clk) disable iff (nrst) !(reg_we_q && store_valid));
    a_exc_pulse:   assert property (@(posedge clk) disable iff (nrst) exc_valid_q |=> !exc_valid_q);
    a_store_hold:  assert property (@(posedge clk) disable iff (nrst)
                                    (store_valid && !store_ready) |=>
                                    (store_valid && $stable(store_id_q)));

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: the driver queues expected events with their cycle,
// the monitor checks every output on each falling edge.
module tb_commit_unit;
    import commit_unit_pkg::*;

    localparam int unsigned FLUSH   = 2;
    localparam logic [6:0]  OPC_ALU = 7'b0110011;
    localparam logic [6:0]  OPC_ST  = 7'b0100011;
    localparam logic [6:0]  OPC_FST = 7'b0100111;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    nrst;
    logic                    i_valid;
    station_t                i_commit_data;
    logic                    i_exception;
    logic                    i_ready;
    logic                    reg_we;
    logic [REG_ADDR_W-1:0]   reg_addr;
    logic [DATA_W-1:0]       reg_data;
    logic                    store_valid;
    logic [N_STATIONS_W-1:0] store_id;
    logic                    store_ready;
    logic                    clear;
    logic                    exc_valid;
    logic [N_STATIONS_W-1:0] exc_id;
    logic [31:0]             retired_count;

    commit_unit #(
        .FLUSH_CYCLES (FLUSH),
        .OPC_STORE    (OPC_ST),
        .OPC_FSTORE   (OPC_FST)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_valid       (i_valid),
        .i_commit_data (i_commit_data),
        .i_exception   (i_exception),
        .i_ready       (i_ready),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_data      (reg_data),
        .store_valid   (store_valid),
        .store_id      (store_id),
        .store_ready   (store_ready),
        .clear         (clear),
        .exc_valid     (exc_valid),
        .exc_id        (exc_id),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t         q_reg[$];
    ev_t         q_exc[$];
    ev_t         q_st[$];
    ev_t         q_clr[$];
    logic [31:0] exp_retired = '0;
    logic        done = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: expected strobes fire exactly in the queued cycle; payloads otherwise hold.
    logic        rst_seen = 1'b0;
    logic [31:0] last_addr = '0, last_data = '0, last_sid = '0, last_eid = '0;
    int          st_end = -1, clr_end = -1;

    initial begin : monitor
        ev_t  e;
        logic exp_we, exp_exc, exp_sv, exp_clr;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                last_addr = '0;
                last_data = '0;
                last_sid  = '0;
                last_eid  = '0;
            end

            exp_we = (q_reg.size() > 0) && (q_reg[0].cyc == cyc);
            if (exp_we) begin
                e = q_reg.pop_front();
                last_addr = e.a;
                last_data = e.b;
            end
            chk("reg_we", 32'(reg_we), 32'(exp_we));
            chk("reg_addr", 32'(reg_addr), last_addr);
            chk("reg_data", reg_data, last_data);

            exp_exc = (q_exc.size() > 0) && (q_exc[0].cyc == cyc);
            if (exp_exc) begin
                e = q_exc.pop_front();
                last_eid = e.a;
            end
            chk("exc_valid", 32'(exc_valid), 32'(exp_exc));
            chk("exc_id", 32'(exc_id), last_eid);

            if ((q_st.size() > 0) && (q_st[0].cyc == cyc)) begin
                e = q_st.pop_front();
                last_sid = e.a;
                st_end = cyc + int'(e.b) - 1;
            end
            exp_sv = (cyc <= st_end);
            chk("store_valid", 32'(store_valid), 32'(exp_sv));
            chk("store_id", 32'(store_id), last_sid);

            if ((q_clr.size() > 0) && (q_clr[0].cyc == cyc)) begin
                e = q_clr.pop_front();
                clr_end = cyc + int'(e.b) - 1;
            end
            exp_clr = (cyc <= clr_end);
            chk("clear", 32'(clear), 32'(exp_clr));

            chk("i_ready", 32'(i_ready), 32'(!(exp_sv || exp_clr)));
            chk("retired_count", retired_count, exp_retired);

            rst_seen = nrst;
            if (done) begin
                chk("pending reg writes", 32'(q_reg.size()), 32'd0);
                chk("pending exceptions", 32'(q_exc.size()), 32'd0);
                chk("pending stores", 32'(q_st.size()), 32'd0);
                chk("pending clears", 32'(q_clr.size()), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one entry at the first cycle i_ready allows; slen/clen are the expected
    // store_valid and clear run lengths for that entry.
    task automatic accept(input logic [3:0] sid, input logic [6:0] opc, input logic [4:0] dst,
                          input logic [31:0] data, input logic inv, input logic exc,
                          input int slen, input int clen);
        int n = 0;
        while (!i_ready) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 64) begin
                $display("FAIL accept timeout: i_ready stuck at 0 for station %0d", sid);
                $fatal(1);
            end
        end
        i_valid       = 1'b1;
        i_exception   = exc;
        i_commit_data = '{invalidate: inv, station_id: sid, opcode: opc, dst_reg: dst,
                          content: data};
        if (!inv) begin
            if (exc) begin
                q_exc.push_back('{cyc + 1, 32'(sid), 32'd0});
                q_clr.push_back('{cyc + 1, 32'd0, 32'(clen)});
            end else if (opc == OPC_ST || opc == OPC_FST) begin
                q_st.push_back('{cyc + 1, 32'(sid), 32'(slen)});
            end else if (dst != '0) begin
                q_reg.push_back('{cyc + 1, 32'(dst), data});
            end
        end
        @(posedge clk);
        #1;
        i_valid     = 1'b0;
        i_exception = 1'b0;
`ifdef COMMIT_COUNTER_EN
        if (!inv && !exc) exp_retired = exp_retired + 32'd1;
`endif
    endtask

    task automatic release_store(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        store_ready = 1'b1;
        @(posedge clk);
        #1;
        store_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : driver
        nrst          = 1'b1;
        i_valid       = 1'b0;
        i_exception   = 1'b0;
        i_commit_data = '0;
        store_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b0;
        idle(1);

        // Plain writes, back to back, including x0 which retires without writing.
        accept(4'd1, OPC_ALU, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0);
        accept(4'd2, OPC_ALU, 5'd31, 32'h1234_5678, 1'b0, 1'b0, 0, 0);
        accept(4'd3, OPC_ALU, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);
        accept(4'd4, OPC_ALU, 5'd0, 32'h5555_5555, 1'b0, 1'b0, 0, 0);

        // Store held for 4 ready-low cycles, then acknowledged.
        accept(4'd3, OPC_ST, 5'd2, 32'h0000_1111, 1'b0, 1'b0, 5, 0);
        release_store(4);

        // Idle acknowledge is ignored; float store sees ready already high.
        store_ready = 1'b1;
        idle(2);
        accept(4'd5, OPC_FST, 5'd0, 32'h0000_2222, 1'b0, 1'b0, 1, 0);
        release_store(0);

        // Exception, then an entry that must wait out the flush.
        accept(4'd7, OPC_ALU, 5'd9, 32'h0000_CAFE, 1'b0, 1'b1, 0, FLUSH);
        accept(4'd8, OPC_ALU, 5'd10, 32'hA5A5_A5A5, 1'b0, 1'b0, 0, 0);

        // Exception on a store opcode; invalidated entries with and without exception.
        accept(4'd2, OPC_ST, 5'd0, 32'h0000_3333, 1'b0, 1'b1, 0, FLUSH);
        accept(4'd4, OPC_ALU, 5'd12, 32'h0000_4444, 1'b1, 1'b1, 0, 0);
        accept(4'd4, OPC_ALU, 5'd13, 32'h0000_5555, 1'b1, 1'b0, 0, 0);
        accept(4'd9, OPC_ST, 5'd0, 32'h0000_6666, 1'b1, 1'b0, 0, 0);

        // Write directly followed by a store.
        accept(4'd10, OPC_ALU, 5'd17, 32'h0F0F_0F0F, 1'b0, 1'b0, 0, 0);
        accept(4'd11, OPC_ST, 5'd0, 32'h0000_7777, 1'b0, 1'b0, 2, 0);
        release_store(1);
        idle(1);

`ifdef COMMIT_COUNTER_EN
        force dut.retired_q = 32'hFFFF_FFFF;
        exp_retired = 32'hFFFF_FFFF;
        idle(1);
        release dut.retired_q;
        accept(4'd1, OPC_ALU, 5'd3, 32'h0BAD_F00D, 1'b0, 1'b0, 0, 0);
        idle(1);
`endif

        // Reset during the first flush cycle aborts the flush.
        accept(4'd9, OPC_ALU, 5'd1, 32'h0000_8888, 1'b0, 1'b1, 0, 1);
        nrst = 1'b1;
        idle(1);
        nrst = 1'b0;
        exp_retired = '0;
        idle(1);

        accept(4'd12, OPC_ALU, 5'd20, 32'h0000_9999, 1'b0, 1'b0, 0, 0);

        // Reset while a store waits for its acknowledge.
        accept(4'd6, OPC_ST, 5'd0, 32'h0000_AAAA, 1'b0, 1'b0, 3, 0);
        idle(2);
        nrst = 1'b1;
        idle(1);
        nrst = 1'b0;
        exp_retired = '0;
        idle(1);

        accept(4'd2, OPC_ALU, 5'd7, 32'h1234_ABCD, 1'b0, 1'b0, 0, 0);
        idle(3);
        done = 1'b1;
    end

endmodule
